seg7_scan: RTL

Time-multiplexed scanner for a multi-digit common-segment 7-segment display. It holds a 16-bit display value and walks one digit slot at a time, presenting that digit's 4-bit nibble to the downstream hex-to-segment decoder. It also drives the matching digit-enable line and decimal point. New values are committed only at frame boundaries, so the display never shows a half-old, half-new value.

---
 rtl/seg7_scan.sv | 115 +++++++++++
 1 files changed

// File: rtl/seg7_scan.sv
// Time-multiplexed 7-segment digit scanner: walks digit slots, presents the nibble,
// decimal point and digit enable for each slot, committing new values only between frames.
module seg7_scan #(
    parameter int DIGITS           = 4,
    parameter int DIV_MAX          = 2999,
    parameter int GUARD            = 2,
    parameter bit DIGIT_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  lz_en,
    output logic [3:0]            nibble_out,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  pending
);

    localparam int DIV_W = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV_MAX);
    localparam logic [DIV_W-1:0]  GUARD_CNT = DIV_W'(GUARD);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] ONE_HOT0  = DIGITS'(1);
    localparam logic [DIGITS-1:0] INACTIVE  = {DIGITS{DIGIT_ACTIVE_LOW}};

    logic [DIV_W-1:0]    div_cnt;
    logic [IDX_W-1:0]    idx;
    logic [4*DIGITS-1:0] pend_val;
    logic [DIGITS-1:0]   pend_dp;
    logic [4*DIGITS-1:0] shadow_val;
    logic [DIGITS-1:0]   shadow_dp;

    logic                tick;
    logic                frame_wrap;
    logic                in_guard;
    logic                blank;
    logic [DIGITS-1:0]   sel;

    assign tick       = (div_cnt == DIV_LAST);
    assign frame_wrap = tick && (idx == IDX_LAST);
    assign in_guard   = (div_cnt < GUARD_CNT);

    // A slot is blanked when it and every more-significant digit are zero.
    always_comb begin
        blank = 1'b0;
        if (lz_en && idx != '0) begin
            blank = 1'b1;
            for (int k = 0; k < DIGITS; k++) begin
                if (k >= int'(idx) && shadow_val[4*k +: 4] != 4'h0) begin
                    blank = 1'b0;
                end
            end
        end
    end

    always_comb begin
        sel = '0;
        if (!in_guard && !blank) begin
            sel = ONE_HOT0 << idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            idx     <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
        end
    end

    // A load coinciding with the frame boundary goes straight to the shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_val   <= '0;
            pend_dp    <= '0;
            pending    <= 1'b0;
            shadow_val <= '0;
            shadow_dp  <= '0;
        end else if (frame_wrap) begin
            if (load) begin
                shadow_val <= value;
                shadow_dp  <= dp_in;
            end else if (pending) begin
                shadow_val <= pend_val;
                shadow_dp  <= pend_dp;
            end
            pending <= 1'b0;
        end else if (load) begin
            pend_val <= value;
            pend_dp  <= dp_in;
            pending  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nibble_out <= 4'h0;
            dp_out     <= 1'b0;
            digit_en   <= INACTIVE;
        end else begin
            nibble_out <= shadow_val[4*idx +: 4];
            dp_out     <= shadow_dp[idx];
            digit_en   <= sel ^ INACTIVE;
        end
    end

endmodule
